bnn_input_loader: RTL
=====================

# bnn_input_loader

Byte-stream loader that fills the BNN network's parallel input ports: the binarised image buffer, the layer-1 kernels and the layer-2 kernels. It sits between the chip's 8-bit input pins and BNN_Network. It accepts framed load commands over a valid/ready byte interface, deserialises each payload into the matching wide register, tracks which targets are loaded, and issues a one-cycle start pulse to the network on a RUN command.

## Interface
Parameters:
- IMG_WIDTH, 30, image side length in pixels; IMG_SIZE = IMG_WIDTH*IMG_WIDTH
- BNN1_CHANL, 8, layer-1 output channels
- BNN2_CHANL, 16, layer-2 output channels
- KERNEL_WIDTH, 3, kernel side length; KERNEL_SIZE = KERNEL_WIDTH*KERNEL_WIDTH
- Derived localparams: IMG_BYTES = ceil(IMG_SIZE/8) (113), K1_BITS = KERNEL_SIZE*BNN1_CHANL (72, 9 bytes), K2_BITS = KERNEL_SIZE*BNN1_CHANL*BNN2_CHANL (1152, 144 bytes)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_data  in  8  command or payload byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- buff  out  IMG_SIZE  image buffer to network
- bnn_layer1_kernel_in  out  K1_BITS  layer-1 kernels
- bnn_layer2_kernel_in  out  K2_BITS  layer-2 kernels
- img_loaded, k1_loaded, k2_loaded  out  1 each  target holds a complete payload
- net_start  out  1  one-cycle start pulse to network
- cmd_err  out  1  sticky protocol error flag

## Operation
- A byte transfers when in_valid && in_ready on a rising edge. No other in_data is consumed.
- FSM states: IDLE, LOAD, START.
- IDLE: the accepted byte is a command.
  - 0x01 selects the image, 0x02 layer-1 kernels, 0x03 layer-2 kernels. The matching loaded flag is cleared, the byte counter is cleared, the target is latched, and the FSM goes to LOAD.
  - 0x04 RUN: if all three flags are 1, go to START. Otherwise set cmd_err and stay in IDLE.
  - 0x00 is a NOP and has no effect.
  - Any other value sets cmd_err and the FSM stays in IDLE.
- LOAD: each accepted byte k (k = 0..N-1, N = byte length of the target) writes target bit 8k+j = in_data[j] for every j with 8k+j < target width.
  - Bits beyond the width are discarded, e.g. image byte 112 uses bits [3:0] only.
  - The counter is 8 bits wide and never exceeds N-1.
  - On the byte with k = N-1: set the target's loaded flag and return to IDLE.
- START: net_start = 1, in_ready = 0, then return to IDLE.
- in_ready = 1 in IDLE and LOAD, and 0 in START.
- Target registers not being loaded hold their value. A partially reloaded target keeps its old bits in positions not yet written, but its flag stays 0 until the load completes.
- Reset clears buff and both kernel registers to all-zero, clears all flags, net_start, cmd_err and the counter, and sets the FSM to IDLE. Any partial load is discarded.
- cmd_err clears only on rst.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1. All other outputs are 0.
- Command accepted at edge N: FSM is in LOAD from N+1. The loaded flag drops at N+1.
- Payload byte accepted at edge M: the corresponding output bits are updated at M+1.
- Last byte accepted at edge M: the loaded flag is 1 and the FSM is in IDLE at M+1. The next command can be accepted at edge M+1, so there are no bubble cycles.
- RUN accepted at edge R: net_start=1 and in_ready=0 for exactly the cycle after R. in_ready returns to 1 the following cycle.
- cmd_err rises the cycle after the offending byte is accepted.
- in_valid low mid-payload stalls with no timeout. State and counter are held indefinitely.
- rst asserted in any state takes effect at that edge and overrides a simultaneous byte transfer.

## Test plan
- Reset, then stream 0x02 + 9 bytes 0x01..0x09 -> bnn_layer1_kernel_in = 0x090807060504030201, k1_loaded=1 on the cycle after byte 9, in_ready never drops.
- Stream 0x01 + 113 bytes 0xFF -> buff all-ones (900 bits), img_loaded=1; last byte bits [7:4] ignored, no cmd_err.
- Load all three targets, then send 0x04 -> net_start high exactly 1 cycle, in_ready low that same cycle, flags stay 1.
- 0x04 with k2 not loaded -> no net_start, cmd_err=1 and sticky. Then 0x7E -> cmd_err remains 1, FSM in IDLE.
- 0x03 + 50 of 144 bytes, then rst -> all outputs 0, k2_loaded=0. A fresh 0x03 + 144 bytes then loads correctly.
- Random in_valid gaps during a layer-2 load -> data identical to the back-to-back case; reloading the image clears img_loaded until its last byte arrives.

Source files
------------

// File: rtl/bnn_input_loader.sv
// Byte-stream loader for the BNN network: framed commands fill the image buffer
// and both kernel registers, track completion flags and pulse net_start on RUN.
module bnn_input_loader #(
  parameter int IMG_WIDTH    = 30,
  parameter int BNN1_CHANL   = 8,
  parameter int BNN2_CHANL   = 16,
  parameter int KERNEL_WIDTH = 3,
  localparam int IMG_SIZE    = IMG_WIDTH * IMG_WIDTH,
  localparam int KERNEL_SIZE = KERNEL_WIDTH * KERNEL_WIDTH,
  localparam int K1_BITS     = KERNEL_SIZE * BNN1_CHANL,
  localparam int K2_BITS     = KERNEL_SIZE * BNN1_CHANL * BNN2_CHANL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IMG_SIZE-1:0] buff,
  output logic [K1_BITS-1:0]  bnn_layer1_kernel_in,
  output logic [K2_BITS-1:0]  bnn_layer2_kernel_in,
  output logic                img_loaded,
  output logic                k1_loaded,
  output logic                k2_loaded,
  output logic                net_start,
  output logic                cmd_err
);

  localparam int IMG_BYTES = (IMG_SIZE + 7) / 8;
  localparam int K1_BYTES  = (K1_BITS + 7) / 8;
  localparam int K2_BYTES  = (K2_BITS + 7) / 8;

  typedef enum logic [1:0] {IDLE, LOAD, START} state_t;
  typedef enum logic [1:0] {T_IMG, T_K1, T_K2} target_t;

  state_t              state_reg;
  target_t             target_reg;
  logic [7:0]          cnt_reg;
  logic [7:0]          last_idx;
  logic                in_ready_reg;
  logic                img_loaded_reg, k1_loaded_reg, k2_loaded_reg;
  logic                net_start_reg, cmd_err_reg;
  logic [IMG_SIZE-1:0] buff_reg, buff_next;
  logic [K1_BITS-1:0]  k1_reg, k1_next;
  logic [K2_BITS-1:0]  k2_reg, k2_next;
  logic                accept, wr_img, wr_k1, wr_k2;

  assign accept = in_valid && in_ready_reg;
  assign wr_img = accept && (state_reg == LOAD) && (target_reg == T_IMG);
  assign wr_k1  = accept && (state_reg == LOAD) && (target_reg == T_K1);
  assign wr_k2  = accept && (state_reg == LOAD) && (target_reg == T_K2);

  always_comb begin
    last_idx = 8'(IMG_BYTES - 1);
    case (target_reg)
      T_K1:    last_idx = 8'(K1_BYTES - 1);
      T_K2:    last_idx = 8'(K2_BYTES - 1);
      default: ;
    endcase
  end

  // Byte k lands in bits [8k +: 8]; the final byte is truncated to the target width.
  genvar gi;
  for (gi = 0; gi < IMG_BYTES; gi++) begin : g_img
    localparam int LO = gi * 8;
    localparam int W  = (IMG_SIZE - LO >= 8) ? 8 : IMG_SIZE - LO;
    assign buff_next[LO +: W] = (wr_img && cnt_reg == 8'(gi)) ? in_data[W-1:0] : buff_reg[LO +: W];
  end
  for (gi = 0; gi < K1_BYTES; gi++) begin : g_k1
    localparam int LO = gi * 8;
    localparam int W  = (K1_BITS - LO >= 8) ? 8 : K1_BITS - LO;
    assign k1_next[LO +: W] = (wr_k1 && cnt_reg == 8'(gi)) ? in_data[W-1:0] : k1_reg[LO +: W];
  end
  for (gi = 0; gi < K2_BYTES; gi++) begin : g_k2
    localparam int LO = gi * 8;
    localparam int W  = (K2_BITS - LO >= 8) ? 8 : K2_BITS - LO;
    assign k2_next[LO +: W] = (wr_k2 && cnt_reg == 8'(gi)) ? in_data[W-1:0] : k2_reg[LO +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      target_reg     <= T_IMG;
      cnt_reg        <= '0;
      in_ready_reg   <= 1'b0;
      img_loaded_reg <= 1'b0;
      k1_loaded_reg  <= 1'b0;
      k2_loaded_reg  <= 1'b0;
      net_start_reg  <= 1'b0;
      cmd_err_reg    <= 1'b0;
      buff_reg       <= '0;
      k1_reg         <= '0;
      k2_reg         <= '0;
    end else begin
      net_start_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      buff_reg      <= buff_next;
      k1_reg        <= k1_next;
      k2_reg        <= k2_next;
      case (state_reg)
        IDLE: if (accept) begin
          case (in_data)
            8'h00: ;
            8'h01: begin img_loaded_reg <= 1'b0; target_reg <= T_IMG; cnt_reg <= '0; state_reg <= LOAD; end
            8'h02: begin k1_loaded_reg  <= 1'b0; target_reg <= T_K1;  cnt_reg <= '0; state_reg <= LOAD; end
            8'h03: begin k2_loaded_reg  <= 1'b0; target_reg <= T_K2;  cnt_reg <= '0; state_reg <= LOAD; end
            8'h04: begin
              if (img_loaded_reg && k1_loaded_reg && k2_loaded_reg) begin
                state_reg     <= START;
                net_start_reg <= 1'b1;
                in_ready_reg  <= 1'b0;
              end else begin
                cmd_err_reg <= 1'b1;
              end
            end
            default: cmd_err_reg <= 1'b1;
          endcase
        end
        LOAD: if (accept) begin
          if (cnt_reg == last_idx) begin
            state_reg <= IDLE;
            case (target_reg)
              T_IMG:   img_loaded_reg <= 1'b1;
              T_K1:    k1_loaded_reg  <= 1'b1;
              T_K2:    k2_loaded_reg  <= 1'b1;
              default: ;
            endcase
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        START:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready             = in_ready_reg;
  assign buff                 = buff_reg;
  assign bnn_layer1_kernel_in = k1_reg;
  assign bnn_layer2_kernel_in = k2_reg;
  assign img_loaded           = img_loaded_reg;
  assign k1_loaded            = k1_loaded_reg;
  assign k2_loaded            = k2_loaded_reg;
  assign net_start            = net_start_reg;
  assign cmd_err              = cmd_err_reg;

endmodule
